// File: rtl/mod_74x163_counter.sv
// mod_74x163_counter: synchronous presettable counter in the 74x160/161/163 style.
// Q cycles 0..MODULO-1. Synchronous clear has priority over parallel load, and load
// has priority over counting. RCO is decoded combinationally from Q and ENT.
// Optional build macro MOD_74X163_DOWN_EN adds the UD direction input (1=up, 0=down).
module mod_74x163_counter #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 2**WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             enp,
  input  logic             ent,
  input  logic [WIDTH-1:0] d,
`ifdef MOD_74X163_DOWN_EN
  input  logic             ud,
`endif
  output logic [WIDTH-1:0] q,
  output logic             rco
);

  // Terminal count in up mode. MODULO never exceeds 2**WIDTH, so this fits in WIDTH bits.
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULO - 1);

  logic             count_en;
  logic [WIDTH-1:0] up_q;
  logic [WIDTH-1:0] q_nxt;

  assign count_en = enp & ent;

  // The >= test wraps both the terminal count and any out-of-range loaded value to 0.
  assign up_q = (q >= TOP) ? '0 : q + 1'b1;

`ifdef MOD_74X163_DOWN_EN
  localparam logic [WIDTH:0] MODV = (WIDTH+1)'(MODULO);

  logic             illegal;
  logic [WIDTH-1:0] dn_q;

  // An out-of-range state reloads the terminal count when counting down, as 0 does.
  assign illegal = ({1'b0, q} >= MODV);
  assign dn_q    = ((q == '0) || illegal) ? TOP : q - 1'b1;
`endif

  // Next-state select with priority clear > load > count > hold.
  always_comb begin
    q_nxt = q;
    if (clr)
      q_nxt = '0;
    else if (load)
      q_nxt = d;
    else if (count_en) begin
`ifdef MOD_74X163_DOWN_EN
      q_nxt = ud ? up_q : dn_q;
`else
      q_nxt = up_q;
`endif
    end
  end

  // State register. CLR acts synchronously, so Q is unknown until the first clearing edge.
  always_ff @(posedge clk) begin
    q <= q_nxt;
  end

  // Ripple carry. ENP is excluded so that stages can be cascaded. An illegal Q never
  // matches the terminal value, so RCO stays low in that case.
  always_comb begin
    rco = 1'b0;
`ifdef MOD_74X163_DOWN_EN
    rco = ent & (ud ? (q == TOP) : (q == '0));
`else
    rco = ent & (q == TOP);
`endif
  end

endmodule

// File: tb/tb_mod_74x163_counter.sv
// tb_mod_74x163_counter: scoreboard bench for a binary counter, a decade counter, and an
// 8-bit cascade built from two stages. The driver pushes the expected post-edge state
// from an integer reference model, and the monitor pops and compares after each edge.
module tb_mod_74x163_counter;

  typedef struct {
    int q16; bit r16;
    int q10; bit r10;
    int qc;  bit rc0; bit rc1;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr, load, enp, ent, ud;
  logic [3:0] d;
  logic       cclr, cen;
  logic [3:0] q16, q10, cq0, cq1;
  logic       r16, r10, crco0, crco1;
  logic       ent1;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m16, m10, mc;

  always #5 clk = ~clk;

  // The stage-1 ENT comes from an AND gate that combines the stage-0 RCO with the system enable.
  assign ent1 = crco0 & cen;

  mod_74x163_counter #(.WIDTH(4)) dut16 (
    .clk(clk), .clr(clr), .load(load), .enp(enp), .ent(ent), .d(d),
`ifdef MOD_74X163_DOWN_EN
    .ud(ud),
`endif
    .q(q16), .rco(r16));

  mod_74x163_counter #(.WIDTH(4), .MODULO(10)) dut10 (
    .clk(clk), .clr(clr), .load(load), .enp(enp), .ent(ent), .d(d),
`ifdef MOD_74X163_DOWN_EN
    .ud(ud),
`endif
    .q(q10), .rco(r10));

  mod_74x163_counter #(.WIDTH(4)) c0 (
    .clk(clk), .clr(cclr), .load(1'b0), .enp(cen), .ent(cen), .d(4'h0),
`ifdef MOD_74X163_DOWN_EN
    .ud(1'b1),
`endif
    .q(cq0), .rco(crco0));

  mod_74x163_counter #(.WIDTH(4)) c1 (
    .clk(clk), .clr(cclr), .load(1'b0), .enp(cen), .ent(ent1), .d(4'h0),
`ifdef MOD_74X163_DOWN_EN
    .ud(1'b1),
`endif
    .q(cq1), .rco(crco1));

  // Reference model, taken directly from the counting rules.
  function automatic int nxt(int q, int m, bit c, bit l, bit p, bit t, int dv, bit u);
    if (c) return 0;
    if (l) return dv;
    if (!(p && t)) return q;
    if (u) return (q >= m - 1) ? 0 : q + 1;
    return (q == 0 || q >= m) ? m - 1 : q - 1;
  endfunction

  function automatic bit rco_of(int q, int m, bit t, bit u);
    return t && (u ? (q == m - 1) : (q == 0));
  endfunction

  task automatic chk(string nm, int act, int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
    end
  endtask

  task automatic step(bit c, bit l, bit p, bit t, int dv, bit u, bit cc, bit ce);
    exp_t e;
    @(negedge clk);
`ifndef MOD_74X163_DOWN_EN
    u = 1'b1;
`endif
    clr = c; load = l; enp = p; ent = t; d = 4'(dv); ud = u;
    cclr = cc; cen = ce;
    m16 = nxt(m16, 16, c, l, p, t, dv, u);
    m10 = nxt(m10, 10, c, l, p, t, dv, u);
    mc  = cc ? 0 : (ce ? (mc + 1) % 256 : mc);
    e.q16 = m16; e.r16 = rco_of(m16, 16, t, u);
    e.q10 = m10; e.r10 = rco_of(m10, 10, t, u);
    e.qc  = mc;
    e.rc0 = ce && (mc % 16 == 15);
    e.rc1 = ce && (mc == 255);
    exp_q.push_back(e);
  endtask

  // Monitor: on every edge, compare all outputs against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("q16",  int'(q16), e.q16);
        chk("rco16", int'(r16), int'(e.r16));
        chk("q10",  int'(q10), e.q10);
        chk("rco10", int'(r10), int'(e.r10));
        chk("cascade_q", int'({cq1, cq0}), e.qc);
        chk("cascade_rco0", int'(crco0), int'(e.rc0));
        chk("cascade_rco1", int'(crco1), int'(e.rc1));
      end
    end
  end

  initial begin
    int cnt;
    clr = 0; load = 0; enp = 0; ent = 0; d = 0; ud = 1; cclr = 0; cen = 0;
    m16 = 0; m10 = 0; mc = 0;
    // Clear first, then 20 up counts: binary wraps 15->0 and decade wraps 9->0.
    step(1, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 1, 0, 1, 0, 1);
    // Count to 7, then assert clear together with load: clear wins. Counting then resumes.
    step(1, 0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 1, 0, 1, 0, 1);
    step(1, 1, 1, 1, 9, 1, 0, 1);
    step(0, 0, 1, 1, 0, 1, 0, 1);
    step(0, 0, 1, 1, 0, 1, 0, 1);
    // Load takes priority over counting. With ENP low, Q holds and RCO follows ENT.
    step(0, 1, 1, 1, 12, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 1, 0, 1);
    step(0, 1, 0, 0, 15, 1, 0, 1);
    step(0, 0, 0, 1, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 1, 0, 1);
    // An out-of-range load holds as-is; the next step wraps the decade counter to 0.
    step(0, 1, 0, 1, 13, 1, 0, 1);
    step(0, 0, 1, 1, 0, 1, 0, 1);
`ifdef MOD_74X163_DOWN_EN
    // Down count from clear: 15,14,...,3, then reverse direction to up -> 4.
    step(1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 13; i++) step(0, 0, 1, 1, 0, 0, 0, 1);
    step(0, 0, 1, 1, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0, 0, 0, 1);
    step(0, 1, 1, 1, 14, 0, 0, 1);
    step(0, 0, 1, 1, 0, 0, 0, 1);
`endif
    // Run the cascade through a full 256-count wrap.
    step(0, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 260; i++) step(0, 0, 1, 1, 0, 1, 0, 1);
    // Randomized mix of all controls.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 15)), $urandom_range(0, 2) != 0,
           $urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0);
    // Wait, with a bound, for the monitor to drain the scoreboard.
    cnt = 0;
    while (exp_q.size() > 0 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    n_cmp++;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
